pq_rr_arbiter: RTL and testbench
================================

Name: pq_rr_arbiter

Overview:
- Shares one min-priority queue core among NUM_REQ independent requesters.
- Each requester issues enqueue, dequeue or replace operations through a valid/ready handshake.
- A round-robin grant selects one eligible requester, issues its operation to the queue as single-cycle strobes, waits out the queue latency, and returns the result with a one-hot response strobe.
- Sits between client logic and the queue core's pq_if device side.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- PQ_LAT, 1, cycles from queue strobe to valid kvo (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_op  in  NUM_REQ x 2  per-requester opcode (pq_op_t).
- req_kv  in  NUM_REQ x kv_t  per-requester key/value for enq/replace.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_kv  out  kv_t  result, broadcast to all requesters.
- pq_enq  out  1  queue enqueue strobe.
- pq_deq  out  1  queue dequeue strobe.
- pq_kvi  out  kv_t  queue input.
- pq_kvo  in  kv_t  queue output (current minimum).
- pq_full  in  1  queue full.
- pq_empty  in  1  queue empty.

Behaviour:
- Opcodes: OP_NOP=00, OP_ENQ=01, OP_DEQ=10, OP_REPL=11.
  - OP_NOP with req_valid=1 is never granted.
- Eligibility of requester i: req_valid[i] and one of:
  - ENQ and !pq_full;
  - DEQ and !pq_empty;
  - REPL and !pq_empty.
- Reset: FSM=IDLE and rr_ptr=0; all outputs held at 0 (req_ready, rsp_valid, rsp_kv, pq_enq, pq_deq, pq_kvi).
- FSM states:
  - IDLE:
    - Pick the first eligible requester scanning from rr_ptr upward with wrap.
    - Same cycle, assert req_ready[winner]=1, combinationally from inputs.
    - Latch winner index, opcode and kv.
    - Set rr_ptr=winner+1 (mod NUM_REQ).
    - Go to ISSUE.
    - No eligible requester: stay in IDLE with all strobes 0.
  - ISSUE (1 cycle):
    - Registered pq_enq=1 for ENQ or REPL.
    - Registered pq_deq=1 for DEQ or REPL.
    - pq_kvi = latched kv.
    - Load wait counter with PQ_LAT-1.
    - Go to WAIT.
  - WAIT:
    - Decrement counter; at 0 go to RESP.
    - Counter width $clog2(PQ_LAT+1); for PQ_LAT=1, WAIT lasts exactly 1 cycle.
  - RESP (1 cycle):
    - rsp_valid[winner]=1.
    - DEQ/REPL: rsp_kv = the kvo value sampled in the ISSUE cycle, i.e. the minimum being removed.
    - ENQ: rsp_kv = 0.
    - Go to IDLE.
- Timing:
  - Grant-to-response latency = PQ_LAT+2 cycles.
  - Throughput is one operation per PQ_LAT+3 cycles.
  - req_ready is never asserted outside IDLE.
- Handshake:
  - A request is committed only on the req_valid & req_ready cycle.
  - A requester may drop or change req_valid/op/kv before grant with no effect.
  - After grant, inputs are ignored until that requester's rsp_valid.
- Full/empty are evaluated only at grant:
  - When full, ENQ requesters are skipped and DEQ/REPL requesters may win.
  - When empty, only ENQ can win.
  - REPL is allowed when full.
- rsp_valid and req_ready are never both asserted for the same requester in one cycle.
- Reset mid-operation: the in-flight op is abandoned, no rsp_valid is produced, and strobes drop to 0 immediately.

Decomposition:
- pq_pkg additions:
  - pq_op_t enum (OP_NOP/ENQ/DEQ/REPL);
  - arbiter state enum;
  - existing kv_t and PQ_CAPACITY reused unchanged.
- One sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: one-hot grant, binary index, any flag.

Test Plan:
- Reset release, no requests: all outputs 0 for 20 cycles; pq_enq/pq_deq never pulse.
- Single ENQ from req 2 (kv key=5, PQ_LAT=1):
  - req_ready[2] at cycle t;
  - pq_enq=1 with pq_kvi key=5 at t+1;
  - rsp_valid[2] at t+3 with rsp_kv=0.
- All 4 requesters hold ENQ continuously from reset:
  - grants in order 0,1,2,3,0;
  - each grant 4 cycles apart for PQ_LAT=1, 11 cycles apart for PQ_LAT=8.
- Queue empty, req 0=DEQ, req 1=ENQ key 7:
  - req 1 granted first;
  - then req 0 granted with rsp_kv key=7;
  - pq_empty asserted afterward.
- pq_full=1, req 0=ENQ, req 1=REPL key 9 with current min key 3:
  - req 1 granted;
  - pq_enq=pq_deq=1 in the same cycle;
  - rsp_kv key=3;
  - req 0 stays ungranted while full.
- rst asserted during WAIT after a DEQ grant:
  - outputs 0 asynchronously;
  - no rsp_valid after release;
  - first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue core and its requester arbiter.
package pq_pkg;

  localparam int unsigned KEY_W       = 16;
  localparam int unsigned VAL_W       = 16;
  localparam int unsigned PQ_CAPACITY = 16;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_REPL = 2'b11
  } pq_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10,
    ARB_RESP  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/pq_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IDX_W'((32'(ptr) + k) % N);
      if (!any && elig[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/pq_rr_arbiter.sv
// Round-robin arbiter sharing one min-priority queue among NUM_REQ requesters;
// one operation in flight at a time, results returned with a one-hot strobe.
module pq_rr_arbiter
  import pq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PQ_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][1:0]  req_op,
  input  kv_t  [NUM_REQ-1:0]       req_kv,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output kv_t                      rsp_kv,
  output logic                     pq_enq,
  output logic                     pq_deq,
  output kv_t                      pq_kvi,
  input  kv_t                      pq_kvo,
  input  logic                     pq_full,
  input  logic                     pq_empty
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(PQ_LAT + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  pq_op_t             op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  kv_t                kvo_q, kvo_d;
  logic               pq_enq_q, pq_enq_d;
  logic               pq_deq_q, pq_deq_d;
  kv_t                pq_kvi_q, pq_kvi_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  kv_t                rsp_kv_q, rsp_kv_d;

  logic [NUM_REQ-1:0] elig_c;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  pq_op_t             win_op_c;

  // Full/empty only matter for the requester being considered this cycle.
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      case (pq_op_t'(req_op[i]))
        OP_ENQ:  elig_c[i] = req_valid[i] && !pq_full;
        OP_DEQ:  elig_c[i] = req_valid[i] && !pq_empty;
        OP_REPL: elig_c[i] = req_valid[i] && !pq_empty;
        default: elig_c[i] = 1'b0;
      endcase
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .elig (elig_c),
    .ptr  (rr_ptr_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign win_op_c  = pq_op_t'(req_op[pick_idx]);
  assign req_ready = (state_q == ARB_IDLE && !rst) ? pick_gnt : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    kvo_d       = kvo_q;
    pq_enq_d    = 1'b0;
    pq_deq_d    = 1'b0;
    pq_kvi_d    = '0;
    rsp_valid_d = '0;
    rsp_kv_d    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d  = ARB_ISSUE;
          idx_d    = pick_idx;
          op_d     = win_op_c;
          rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          pq_enq_d = (win_op_c == OP_ENQ) || (win_op_c == OP_REPL);
          pq_deq_d = (win_op_c == OP_DEQ) || (win_op_c == OP_REPL);
          pq_kvi_d = req_kv[pick_idx];
        end
      end
      ARB_ISSUE: begin
        // kvo still shows the pre-operation minimum during the strobe cycle.
        state_d = ARB_WAIT;
        cnt_d   = CNT_W'(PQ_LAT - 1);
        kvo_d   = pq_kvo;
      end
      ARB_WAIT: begin
        if (cnt_q == '0) begin
          state_d            = ARB_RESP;
          rsp_valid_d[idx_q] = 1'b1;
          rsp_kv_d           = (op_q == OP_ENQ) ? '0 : kvo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      op_q        <= OP_NOP;
      cnt_q       <= '0;
      kvo_q       <= '0;
      pq_enq_q    <= 1'b0;
      pq_deq_q    <= 1'b0;
      pq_kvi_q    <= '0;
      rsp_valid_q <= '0;
      rsp_kv_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      kvo_q       <= kvo_d;
      pq_enq_q    <= pq_enq_d;
      pq_deq_q    <= pq_deq_d;
      pq_kvi_q    <= pq_kvi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_kv_q    <= rsp_kv_d;
    end
  end

  assign pq_enq    = pq_enq_q;
  assign pq_deq    = pq_deq_q;
  assign pq_kvi    = pq_kvi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_kv    = rsp_kv_q;

endmodule

// File: tb/tb_pq_rr_arbiter.sv
// Scoreboard bench for pq_rr_arbiter: directed requests against a small behavioural
// queue, plus a second instance with PQ_LAT=8 for round-robin spacing.
module tb_pq_rr_arbiter;
  import pq_pkg::*;

  localparam int NR   = 4;
  localparam int LAT  = 1;
  localparam int LAT8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0][1:0]   req_op = '0;
  kv_t  [NR-1:0]        req_kv = '0;
  logic [NR-1:0]        req_ready, rsp_valid;
  kv_t                  rsp_kv, pq_kvi;
  logic                 pq_enq, pq_deq;
  kv_t                  pq_kvo = '0;
  logic                 pq_full = 1'b0;
  logic                 pq_empty = 1'b1;

  pq_rr_arbiter #(.NUM_REQ(NR), .PQ_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_kv(req_kv),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_kv(rsp_kv),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
    .pq_full(pq_full), .pq_empty(pq_empty)
  );

  logic                 rst8 = 1'b0;
  logic [NR-1:0]        req_valid8 = '0;
  logic [NR-1:0][1:0]   req_op8 = '0;
  kv_t  [NR-1:0]        req_kv8 = '0;
  logic [NR-1:0]        req_ready8, rsp_valid8;
  kv_t                  rsp_kv8, pq_kvi8;
  logic                 pq_enq8, pq_deq8;
  kv_t                  pq_kvo8 = '0;
  logic                 pq_full8 = 1'b0;
  logic                 pq_empty8 = 1'b1;

  pq_rr_arbiter #(.NUM_REQ(NR), .PQ_LAT(LAT8)) u_dut8 (
    .clk(clk), .rst(rst8), .req_valid(req_valid8), .req_op(req_op8), .req_kv(req_kv8),
    .req_ready(req_ready8), .rsp_valid(rsp_valid8), .rsp_kv(rsp_kv8),
    .pq_enq(pq_enq8), .pq_deq(pq_deq8), .pq_kvi(pq_kvi8), .pq_kvo(pq_kvo8),
    .pq_full(pq_full8), .pq_empty(pq_empty8)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic kv_t mkkv(input int k, input int v);
    kv_t r;
    r.key = 16'(k);
    r.val = 16'(v);
    return r;
  endfunction

  // Behavioural min-queue: kvo/full/empty follow the strobes one cycle later.
  kv_t         mq[$];
  int unsigned full_lim = PQ_CAPACITY;

  always @(posedge clk) begin : model
    int p;
    p = 0;
    if (pq_deq && mq.size() > 0) void'(mq.pop_front());
    if (pq_enq) begin
      while (p < mq.size() && mq[p].key <= pq_kvi.key) p++;
      mq.insert(p, pq_kvi);
    end
    if (mq.size() > 0) pq_kvo <= mq[0];
    else               pq_kvo <= '0;
    pq_empty <= (mq.size() == 0);
    pq_full  <= (mq.size() >= full_lim);
  end

  typedef struct {
    int   idx;
    logic enq;
    logic deq;
    kv_t  kvi;
    kv_t  rkv;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic busy = 1'b0;
  int   gcyc = 0;

  function automatic exp_t mk(input int idx, input logic enq, input logic deq,
                              input kv_t kvi, input kv_t rkv);
    exp_t e;
    e.idx = idx; e.enq = enq; e.deq = deq; e.kvi = kvi; e.rkv = rkv;
    return e;
  endfunction

  // Monitor: pops an expectation on each grant, then checks strobe and response timing.
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
    end else begin
      check("ready_rsp_overlap", 64'(req_ready & rsp_valid), 64'(0));
      if (req_ready != '0) begin
        if (busy || exp_q.size() == 0) begin
          check("unexpected_grant", 64'(req_ready), 64'(0));
        end else begin
          cur  = exp_q.pop_front();
          busy = 1'b1;
          gcyc = cyc;
          check("grant", 64'(req_ready), 64'(1) << cur.idx);
        end
      end
      if (busy && cyc == gcyc + 1) begin
        check("pq_strobes", 64'({pq_enq, pq_deq}), 64'({cur.enq, cur.deq}));
        check("pq_kvi", 64'(pq_kvi), 64'(cur.kvi));
      end else begin
        check("stray_strobe", 64'({pq_enq, pq_deq}), 64'(0));
      end
      if (busy && cyc == gcyc + LAT + 2) begin
        check("rsp_valid", 64'(rsp_valid), 64'(1) << cur.idx);
        check("rsp_kv", 64'(rsp_kv), 64'(cur.rkv));
        busy = 1'b0;
      end else begin
        check("stray_rsp", 64'(rsp_valid), 64'(0));
      end
    end
  end

  task automatic do_req(input int i, input pq_op_t op, input kv_t kv);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_kv[i]    = kv;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 200);
    check($sformatf("granted_req%0d", i), 64'(req_ready[i]), 64'(1));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'({busy, exp_q.size() != 0}), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input int unsigned lim, input int preload_key);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    mq.delete();
    full_lim  = lim;
    if (preload_key >= 0) mq.push_back(mkkv(preload_key, preload_key * 'h11));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // PQ_LAT=8 instance: all four hold ENQ from reset; expect 0,1,2,3,0 spaced 11 apart.
  int   exp8[$] = '{0, 1, 2, 3, 0};
  int   g8 = 0;
  int   g8cyc = 0;
  int   g8idx = 0;
  logic g8busy = 1'b0;
  logic done8 = 1'b0;

  always @(negedge clk) begin
    if (!rst8) begin
      if (req_ready8 != '0) begin
        if (exp8.size() == 0) begin
          check("lat8_unexpected_grant", 64'(req_ready8), 64'(0));
        end else begin
          g8idx = exp8.pop_front();
          check("lat8_grant", 64'(req_ready8), 64'(1) << g8idx);
          if (g8 > 0) check("lat8_spacing", 64'(cyc - g8cyc), 64'(LAT8 + 3));
          g8cyc  = cyc;
          g8     = g8 + 1;
          g8busy = 1'b1;
        end
      end
      if (g8busy && cyc == g8cyc + LAT8 + 2) begin
        check("lat8_rsp_valid", 64'(rsp_valid8), 64'(1) << g8idx);
        check("lat8_rsp_kv", 64'(rsp_kv8), 64'(0));
        g8busy = 1'b0;
      end else begin
        check("lat8_stray_rsp", 64'(rsp_valid8), 64'(0));
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      req_op8[i] = OP_ENQ;
      req_kv8[i] = mkkv(i + 1, 0);
    end
    #1 rst8 = 1'b1;
    req_valid8 = '1;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b0;
    n = 0;
    while (g8 < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid8 = '0;
    n = 0;
    while (g8busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    done8 = 1'b1;
  end

  initial begin
    int n;
    int prev;

    // Reset: outputs held at 0 even with a request pending.
    #1 rst = 1'b1;
    req_valid[0] = 1'b1;
    req_op[0]    = OP_ENQ;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_strobes", 64'({pq_enq, pq_deq}), 64'(0));
    check("rst_data", 64'({pq_kvi, rsp_kv}), 64'(0));
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle with no requests.
    repeat (20) begin
      @(negedge clk);
      check("idle_ctl", 64'({req_ready, rsp_valid, pq_enq, pq_deq}), 64'(0));
      check("idle_data", 64'({pq_kvi, rsp_kv}), 64'(0));
    end

    // Single ENQ from requester 2.
    exp_q.push_back(mk(2, 1'b1, 1'b0, mkkv(5, 'h55), '0));
    do_req(2, OP_ENQ, mkkv(5, 'h55));
    wait_drain();

    // All four hold ENQ from reset: strict rotation, one grant per PQ_LAT+3 cycles.
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete();
    full_lim = PQ_CAPACITY;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b1;
      req_op[i]    = OP_ENQ;
      req_kv[i]    = mkkv(10 + i, 'h100 + i);
    end
    for (int k = 0; k < 5; k++)
      exp_q.push_back(mk(k % NR, 1'b1, 1'b0, mkkv(10 + k % NR, 'h100 + k % NR), '0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == '0 && n < 50);
      check("rr_grant_seen", 64'(|req_ready), 64'(1));
      if (k > 0) check("rr_spacing", 64'(cyc - prev), 64'(LAT + 3));
      prev = cyc;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    // Empty queue: DEQ on 0 must wait for ENQ key 7 on 1, then returns 7.
    do_reset(PQ_CAPACITY, -1);
    exp_q.push_back(mk(1, 1'b1, 1'b0, mkkv(7, 'h77), '0));
    exp_q.push_back(mk(0, 1'b0, 1'b1, mkkv('hee, 'h0e), mkkv(7, 'h77)));
    fork
      do_req(0, OP_DEQ, mkkv('hee, 'h0e));
      do_req(1, OP_ENQ, mkkv(7, 'h77));
    join
    wait_drain();

    // Full queue holding min 3: REPL key 9 wins, ENQ stays blocked.
    do_reset(1, 3);
    req_valid[0] = 1'b1;
    req_op[0]    = OP_ENQ;
    req_kv[0]    = mkkv(1, 1);
    exp_q.push_back(mk(1, 1'b1, 1'b1, mkkv(9, 'h99), mkkv(3, 'h33)));
    do_req(1, OP_REPL, mkkv(9, 'h99));
    wait_drain();
    repeat (20) begin
      @(negedge clk);
      check("full_enq_blocked", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;

    // Reset while waiting on a DEQ: abandoned, and the pointer returns to 0.
    do_reset(PQ_CAPACITY, 4);
    exp_q.push_back(mk(2, 1'b0, 1'b1, mkkv('h22, 'h22), mkkv(4, 'h44)));
    do_req(2, OP_DEQ, mkkv('h22, 'h22));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ctl", 64'({req_ready, rsp_valid, pq_enq, pq_deq}), 64'(0));
    check("midrst_data", 64'({pq_kvi, rsp_kv}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_pending", 64'(busy), 64'(0));
    exp_q.push_back(mk(0, 1'b1, 1'b0, mkkv(1, 1), '0));
    exp_q.push_back(mk(3, 1'b1, 1'b0, mkkv(2, 2), '0));
    fork
      do_req(0, OP_ENQ, mkkv(1, 1));
      do_req(3, OP_ENQ, mkkv(2, 2));
    join
    wait_drain();

    n = 0;
    while (!done8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("lat8_done", 64'(done8), 64'(1));
    check("lat8_grants", 64'(g8), 64'(5));
    check("exp_left", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
